// File: rtl/des_key_schedule_if.sv
// rtl/des_key_schedule_if.sv - key load/advance controls and round key outputs of the DES key schedule
interface des_key_schedule_if;
  logic [63:0] key_in;
  logic        load;
  logic        decrypt;
  logic        advance;
  logic [47:0] round_key;
  logic [3:0]  round_num;
  logic        key_valid;
  logic        done;

  modport master (
    output key_in, load, decrypt, advance,
    input  round_key, round_num, key_valid, done
  );

  modport slave (
    input  key_in, load, decrypt, advance,
    output round_key, round_num, key_valid, done
  );
endinterface

// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - iterative DES key schedule, one 48-bit subkey per round
// PC-2 is a fixed permutation, so round_key is plain rewiring of the C/D flops.
module des_key_schedule (
  input  logic                clk,
  input  logic                rst,
  des_key_schedule_if.slave   ks
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Bit n set when round n rotates by two; rounds 1, 2, 9 and 16 rotate by one.
  localparam logic [31:0] SHIFT2 = {15'd0, 16'b0111111011111100, 1'b0};

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1[i[5:0]])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2[i[5:0]])];
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_t      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  round_q, round_d;
  logic        dec_q, dec_d;
  logic        done_q, done_d;
  logic [55:0] cd0;
  logic [4:0]  shift_idx;
  logic        two;

  assign cd0 = pc1(ks.key_in);

  // Encrypt steps into round r+2, decrypt undoes the shift of round 16-r.
  assign shift_idx = dec_q ? (5'd16 - {1'b0, round_q}) : ({1'b0, round_q} + 5'd2);
  assign two       = SHIFT2[shift_idx];

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    d_d     = d_q;
    round_d = round_q;
    dec_d   = dec_q;
    done_d  = 1'b0;
    if (ks.load) begin
      c_d     = ks.decrypt ? cd0[55:28] : rotl(cd0[55:28], 1'b0);
      d_d     = ks.decrypt ? cd0[27:0]  : rotl(cd0[27:0], 1'b0);
      round_d = 4'd0;
      dec_d   = ks.decrypt;
      state_d = ACTIVE;
    end else if (ks.advance && state_q == ACTIVE) begin
      if (round_q == 4'd15) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        c_d     = dec_q ? rotr(c_q, two) : rotl(c_q, two);
        d_d     = dec_q ? rotr(d_q, two) : rotl(d_q, two);
        round_d = round_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      d_q     <= d_d;
      round_q <= round_d;
      dec_q   <= dec_d;
      done_q  <= done_d;
    end
  end

  assign ks.round_key = pc2({c_q, d_q});
  assign ks.round_num = round_q;
  assign ks.key_valid = (state_q == ACTIVE);
  assign ks.done      = done_q;

endmodule

// File: doc/des_key_schedule.md
# des_key_schedule

Iterative DES key schedule generating one 48-bit round subkey per round for the Feistel round datapath. Its `round_key` output is XORed with the 48-bit output of the expansion stage, ahead of the S-box stage. It performs PC-1 on load, applies per-round left rotations for encryption or right rotations for decryption, and applies PC-2 to the current C/D halves. Bit numbering is MSB-first throughout: DES bit n of a W-bit vector is vector bit [W-n].

## Interface

Parameters: none. The rotation schedule and the PC-1/PC-2 tables are fixed per FIPS 46-3.

- `clk`  in  1  Single clock, rising-edge.
- `rst`  in  1  Synchronous, active-high reset.
- `key_in`  in  64  DES key. Parity bits (DES bits 8, 16, …, 64) are ignored by PC-1.
- `load`  in  1  Capture `key_in` and start a 16-round sequence.
- `decrypt`  in  1  Direction, sampled only with `load`. 0 = K1→K16, 1 = K16→K1.
- `advance`  in  1  Step to the next round key.
- `round_key`  out  48  PC-2 of the current C/D registers. Pure wiring from flops, no logic in between.
- `round_num`  out  4  Current round index minus 1 (0..15).
- `key_valid`  out  1  High while `round_key` is a valid subkey.
- `done`  out  1  One-cycle pulse after the last round key is consumed.

## Operation

- State: 28-bit `C` and `D` registers, a 4-bit round counter, a direction flag, and a two-state FSM (IDLE, ACTIVE).
- Rotation schedule by round 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- `load` in either state:
  - Computes {C0,D0} = PC-1(`key_in`).
  - Encrypt: C/D ← C0/D0 rotated left by 1, so the held key is K1.
  - Decrypt: C/D ← C0/D0 unrotated, because the total rotation is 28 and C0/D0 therefore yields K16.
  - Sets round counter to 0, latches `decrypt`, and enters ACTIVE.
- `advance` in ACTIVE with `round_num` = r < 15:
  - Encrypt: rotate C/D left by shift(r+2), giving K(r+2).
  - Decrypt: rotate C/D right by shift(16-r), giving K(15-r).
  - Increment the round counter.
- `advance` in ACTIVE with `round_num` = 15: go to IDLE, drop `key_valid`, pulse `done`. C/D are left unchanged.
- `advance` in IDLE: ignored. No `done` pulse.
- Simultaneous `load` and `advance`: `load` wins and the sequence restarts.
- `decrypt` changes while ACTIVE have no effect until the next `load`.
- In IDLE, `round_key` holds its last value. Consumers must qualify it with `key_valid`.

## Timing

- Reset values: C = D = 0, `round_key` = 0, `round_num` = 0, `key_valid` = 0, `done` = 0, FSM = IDLE, direction = encrypt.
- `rst` asserted mid-sequence: next cycle returns to reset values. `rst` overrides `load`.
- Load latency: `load` sampled at edge N gives the first key, `key_valid` = 1 and `round_num` = 0 after edge N.
- Advance latency: one cycle. With `advance` held continuously, the 16 keys occupy 16 consecutive cycles.
- After `advance` at `round_num` = 15, following the edge: `key_valid` = 0 and `done` = 1 for exactly one cycle.
- `load` in the same cycle as the final `advance`: `load` wins, so there is no `done` and the new K1/K16 is presented.
- No combinational path from inputs to outputs.

## Test plan

- **Reset:** assert `rst` 2 cycles → all outputs 0. `advance` pulses while IDLE → `key_valid` and `done` stay 0.
- **Encrypt sequence:** `key_in`=0x133457799BBCDFF1, `decrypt`=0, `load`, then hold `advance`:
  - cycle 1: `round_key`=0x1B02EFFC7072
  - next: 0x79AED9DBC9E5
  - 16th: 0xCB3D8B0E17F5
  - then `done` for 1 cycle with `key_valid`=0.
- **Decrypt sequence:** same key with `decrypt`=1:
  - first key 0xCB3D8B0E17F5, `round_num`=0
  - keys are the encrypt sequence reversed
  - 16th key 0x1B02EFFC7072.
- **Stall tolerance:** random `advance` gaps → `round_key`/`round_num` hold during gaps. Sequence matches the back-to-back case.
- **Reload mid-sequence:** `load` at `round_num`=7, including `load` and `advance` together → restarts at K1 with `round_num`=0 and no `done`. New `decrypt` value takes effect.
- **Reset mid-sequence:** `rst` at `round_num`=5 together with `load` → all outputs 0 and IDLE on the next cycle.
